// File: rtl/ctrl_pipe.sv
`default_nettype none
// ============================================================================
// ctrl_pipe : carries decoded control through ID/EX, EX/MEM, MEM/WB and
//             generates the load-use stall and the branch-taken flush.
// Rev 1.0
// ============================================================================
module ctrl_pipe #(
    parameter int AOP_W = 3,
    parameter int RA_W  = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic             id_regds,
    input  logic             id_branch,
    input  logic             id_mread,
    input  logic             id_mtor,
    input  logic [AOP_W-1:0] id_aop,
    input  logic             id_mwrite,
    input  logic             id_alusrc,
    input  logic             id_urw,
    input  logic [RA_W-1:0]  id_rs,
    input  logic [RA_W-1:0]  id_rt,
    input  logic [RA_W-1:0]  id_wr,
    input  logic             ex_zero,
    output logic             ex_valid,
    output logic             ex_regds,
    output logic [AOP_W-1:0] ex_aop,
    output logic             ex_alusrc,
    output logic             mem_valid,
    output logic             mem_branch,
    output logic             mem_mread,
    output logic             mem_mwrite,
    output logic             wb_valid,
    output logic             wb_mtor,
    output logic             wb_urw,
    output logic [RA_W-1:0]  wb_wr,
    output logic             ld_stall,
    output logic             pc_src
);

    logic             r_ex_valid;
    logic             r_ex_regds;
    logic             r_ex_branch;
    logic             r_ex_mread;
    logic             r_ex_mtor;
    logic [AOP_W-1:0] r_ex_aop;
    logic             r_ex_mwrite;
    logic             r_ex_alusrc;
    logic             r_ex_urw;
    logic [RA_W-1:0]  r_ex_wr;

    logic             r_mem_valid;
    logic             r_mem_branch;
    logic             r_mem_mread;
    logic             r_mem_mtor;
    logic             r_mem_mwrite;
    logic             r_mem_urw;
    logic [RA_W-1:0]  r_mem_wr;
    logic             r_mem_zero;

    logic             r_wb_valid;
    logic             r_wb_mtor;
    logic             r_wb_urw;
    logic [RA_W-1:0]  r_wb_wr;

    logic             w_pc_src;
    logic             w_ld_stall;
    logic             w_id_load;
    logic             w_ex_hazard;

    assign w_pc_src    = r_mem_valid & r_mem_branch & r_mem_zero;
    assign w_ex_hazard = r_ex_valid & r_ex_mread & r_ex_urw & (r_ex_wr != '0)
                       & ((r_ex_wr == id_rs) | (r_ex_wr == id_rt));
    // A taken branch squashes the instruction in ID, so it can never stall.
    assign w_ld_stall  = w_ex_hazard & id_valid & ~w_pc_src;
    assign w_id_load   = id_valid & ~w_ld_stall & ~w_pc_src;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex_valid  <= 1'b0;
            r_ex_regds  <= 1'b0;
            r_ex_branch <= 1'b0;
            r_ex_mread  <= 1'b0;
            r_ex_mtor   <= 1'b0;
            r_ex_aop    <= '0;
            r_ex_mwrite <= 1'b0;
            r_ex_alusrc <= 1'b0;
            r_ex_urw    <= 1'b0;
            r_ex_wr     <= '0;
        end else if (w_id_load) begin
            r_ex_valid  <= 1'b1;
            r_ex_regds  <= id_regds;
            r_ex_branch <= id_branch;
            r_ex_mread  <= id_mread;
            r_ex_mtor   <= id_mtor;
            r_ex_aop    <= id_aop;
            r_ex_mwrite <= id_mwrite;
            r_ex_alusrc <= id_alusrc;
            r_ex_urw    <= id_urw;
            r_ex_wr     <= id_wr;
        end else begin
            // Bubble: fully zeroed so decoder don't-care fields never leak.
            r_ex_valid  <= 1'b0;
            r_ex_regds  <= 1'b0;
            r_ex_branch <= 1'b0;
            r_ex_mread  <= 1'b0;
            r_ex_mtor   <= 1'b0;
            r_ex_aop    <= '0;
            r_ex_mwrite <= 1'b0;
            r_ex_alusrc <= 1'b0;
            r_ex_urw    <= 1'b0;
            r_ex_wr     <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || w_pc_src) begin
            r_mem_valid  <= 1'b0;
            r_mem_branch <= 1'b0;
            r_mem_mread  <= 1'b0;
            r_mem_mtor   <= 1'b0;
            r_mem_mwrite <= 1'b0;
            r_mem_urw    <= 1'b0;
            r_mem_wr     <= '0;
            r_mem_zero   <= 1'b0;
        end else begin
            r_mem_valid  <= r_ex_valid;
            r_mem_branch <= r_ex_branch;
            r_mem_mread  <= r_ex_mread;
            r_mem_mtor   <= r_ex_mtor;
            r_mem_mwrite <= r_ex_mwrite;
            r_mem_urw    <= r_ex_urw;
            r_mem_wr     <= r_ex_wr;
            r_mem_zero   <= r_ex_valid & ex_zero;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wb_valid <= 1'b0;
            r_wb_mtor  <= 1'b0;
            r_wb_urw   <= 1'b0;
            r_wb_wr    <= '0;
        end else begin
            r_wb_valid <= r_mem_valid;
            r_wb_mtor  <= r_mem_mtor;
            r_wb_urw   <= r_mem_urw;
            r_wb_wr    <= r_mem_wr;
        end
    end

    assign ex_valid   = r_ex_valid;
    assign ex_regds   = r_ex_regds;
    assign ex_aop     = r_ex_aop;
    assign ex_alusrc  = r_ex_alusrc;
    assign mem_valid  = r_mem_valid;
    assign mem_branch = r_mem_branch;
    assign mem_mread  = r_mem_mread;
    assign mem_mwrite = r_mem_mwrite;
    assign wb_valid   = r_wb_valid;
    assign wb_mtor    = r_wb_mtor;
    assign wb_urw     = r_wb_urw;
    assign wb_wr      = r_wb_wr;
    assign ld_stall   = w_ld_stall;
    assign pc_src     = w_pc_src;

endmodule
`default_nettype wire

// File: tb/tb_ctrl_pipe.sv
`default_nettype none
// ============================================================================
// tb_ctrl_pipe : directed stimulus with a WB retirement scoreboard.
// Rev 1.0
// ============================================================================
module tb_ctrl_pipe;

    logic       clk;
    logic       rst_n;
    logic       id_valid, id_regds, id_branch, id_mread, id_mtor;
    logic [2:0] id_aop;
    logic       id_mwrite, id_alusrc, id_urw;
    logic [4:0] id_rs, id_rt, id_wr;
    logic       ex_zero;
    logic       ex_valid, ex_regds, ex_alusrc;
    logic [2:0] ex_aop;
    logic       mem_valid, mem_branch, mem_mread, mem_mwrite;
    logic       wb_valid, wb_mtor, wb_urw;
    logic [4:0] wb_wr;
    logic       ld_stall, pc_src;

    int n_err = 0;
    int n_chk = 0;
    logic [6:0] sb[$];   // {mtor, urw, wr} of each instruction expected to retire

    ctrl_pipe #(.AOP_W(3), .RA_W(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_regds(id_regds), .id_branch(id_branch),
        .id_mread(id_mread), .id_mtor(id_mtor), .id_aop(id_aop),
        .id_mwrite(id_mwrite), .id_alusrc(id_alusrc), .id_urw(id_urw),
        .id_rs(id_rs), .id_rt(id_rt), .id_wr(id_wr), .ex_zero(ex_zero),
        .ex_valid(ex_valid), .ex_regds(ex_regds), .ex_aop(ex_aop), .ex_alusrc(ex_alusrc),
        .mem_valid(mem_valid), .mem_branch(mem_branch), .mem_mread(mem_mread),
        .mem_mwrite(mem_mwrite), .wb_valid(wb_valid), .wb_mtor(wb_mtor),
        .wb_urw(wb_urw), .wb_wr(wb_wr), .ld_stall(ld_stall), .pc_src(pc_src)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && wb_valid) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_err++;
                $display("FAIL wb_unexpected: got wr=%0d urw=%0b expected no retirement", wb_wr, wb_urw);
            end else begin
                logic [6:0] e;
                e = sb.pop_front();
                chk("wb_retire", {wb_mtor, wb_urw, wb_wr}, {25'd0, e});
            end
        end
    end

    task automatic drv(input logic regds, branch, mread, mtor, input logic [2:0] aop,
                       input logic mwrite, alusrc, urw, input logic [4:0] rs, rt, wr);
        id_valid = 1'b1; id_regds = regds; id_branch = branch; id_mread = mread;
        id_mtor = mtor; id_aop = aop; id_mwrite = mwrite; id_alusrc = alusrc;
        id_urw = urw; id_rs = rs; id_rt = rt; id_wr = wr;
    endtask

    // Invalid ID with every field set, so any leak of don't-care fields shows up.
    task automatic bub();
        id_valid = 1'b0; id_regds = 1'b1; id_branch = 1'b1; id_mread = 1'b1;
        id_mtor = 1'b1; id_aop = 3'b111; id_mwrite = 1'b1; id_alusrc = 1'b1;
        id_urw = 1'b1; id_rs = 5'd31; id_rt = 5'd31; id_wr = 5'd31;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic drain();
        bub();
        repeat (4) cyc();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        ex_zero = 1'b0;
        bub();
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        // Reset state
        smp();
        chk("rst_ex_valid", ex_valid, 0);
        chk("rst_mem_valid", mem_valid, 0);
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_wb_wr", wb_wr, 0);
        chk("rst_ld_stall", ld_stall, 0);
        chk("rst_pc_src", pc_src, 0);

        // R-type through the pipe
        drv(1, 0, 0, 1, 3'b010, 0, 0, 1, 5'd1, 5'd2, 5'd5);
        sb.push_back({1'b1, 1'b1, 5'd5});
        cyc();
        bub();
        smp();
        chk("r_ex_valid", ex_valid, 1);
        chk("r_ex_regds", ex_regds, 1);
        chk("r_ex_aop", ex_aop, 3'b010);
        chk("r_ex_alusrc", ex_alusrc, 0);
        cyc(); smp();
        chk("r_mem_valid", mem_valid, 1);
        chk("r_ex_bubble", ex_valid, 0);
        chk("r_bubble_aop", ex_aop, 0);
        cyc(); smp();
        chk("r_wb_valid", wb_valid, 1);
        chk("r_wb_wr", wb_wr, 5);
        cyc(); smp();
        chk("r_wb_after", wb_valid, 0);

        // Load-use stall on rs
        drv(0, 0, 1, 1, 3'b000, 0, 1, 1, 5'd1, 5'd0, 5'd8);
        sb.push_back({1'b1, 1'b1, 5'd8});
        cyc();
        drv(1, 0, 0, 0, 3'b010, 0, 0, 1, 5'd8, 5'd3, 5'd9);
        sb.push_back({1'b0, 1'b1, 5'd9});
        smp();
        chk("lu_stall", ld_stall, 1);
        cyc(); smp();
        chk("lu_stall_drop", ld_stall, 0);
        chk("lu_ex_bubble", ex_valid, 0);
        chk("lu_mem_mread", mem_mread, 1);
        cyc();
        bub();
        smp();
        chk("lu_dep_ex", ex_valid, 1);
        chk("lu_dep_regds", ex_regds, 1);
        drain();

        // Load to r0 never stalls; then rt-side hazard stalls
        drv(0, 0, 1, 1, 3'b000, 0, 1, 1, 5'd2, 5'd0, 5'd0);
        sb.push_back({1'b1, 1'b1, 5'd0});
        cyc();
        drv(1, 0, 0, 0, 3'b010, 0, 0, 1, 5'd0, 5'd0, 5'd10);
        sb.push_back({1'b0, 1'b1, 5'd10});
        smp();
        chk("r0_no_stall", ld_stall, 0);
        cyc();
        drv(0, 0, 1, 1, 3'b000, 0, 1, 1, 5'd2, 5'd0, 5'd7);
        sb.push_back({1'b1, 1'b1, 5'd7});
        smp();
        chk("r0_consumer_ex", ex_valid, 1);
        cyc();
        drv(1, 0, 0, 0, 3'b010, 0, 0, 1, 5'd4, 5'd7, 5'd6);
        sb.push_back({1'b0, 1'b1, 5'd6});
        smp();
        chk("rt_stall", ld_stall, 1);
        cyc(); cyc();
        drain();

        // Taken branch squashes two followers
        drv(0, 1, 0, 0, 3'b001, 0, 0, 0, 5'd1, 5'd2, 5'd0);
        sb.push_back({1'b0, 1'b0, 5'd0});
        cyc();
        ex_zero = 1'b1;
        drv(0, 0, 0, 0, 3'b000, 1, 1, 0, 5'd1, 5'd3, 5'd0);
        smp();
        chk("tb_pc_src_early", pc_src, 0);
        cyc();
        ex_zero = 1'b0;
        drv(1, 0, 0, 0, 3'b010, 0, 0, 1, 5'd4, 5'd5, 5'd11);
        smp();
        chk("tb_pc_src", pc_src, 1);
        chk("tb_mem_branch", mem_branch, 1);
        cyc();
        bub();
        smp();
        chk("tb_pc_src_drop", pc_src, 0);
        chk("tb_ex_squash", ex_valid, 0);
        chk("tb_mem_squash", mem_valid, 0);
        chk("tb_wb_branch", wb_valid, 1);
        cyc(); smp();
        chk("tb_no_mwrite", mem_mwrite, 0);
        chk("tb_no_urw", wb_urw, 0);
        drain();

        // Not-taken branch: followers retire
        drv(0, 1, 0, 0, 3'b001, 0, 0, 0, 5'd1, 5'd2, 5'd0);
        sb.push_back({1'b0, 1'b0, 5'd0});
        cyc();
        drv(0, 0, 0, 0, 3'b000, 1, 1, 0, 5'd1, 5'd3, 5'd0);
        sb.push_back({1'b0, 1'b0, 5'd0});
        cyc();
        drv(1, 0, 0, 0, 3'b010, 0, 0, 1, 5'd4, 5'd5, 5'd11);
        sb.push_back({1'b0, 1'b1, 5'd11});
        smp();
        chk("nt_pc_src", pc_src, 0);
        cyc();
        bub();
        smp();
        chk("nt_ex_valid", ex_valid, 1);
        chk("nt_mem_mwrite", mem_mwrite, 1);
        drain();

        // Taken branch beats a load-use hazard; load squashed
        drv(0, 1, 0, 0, 3'b001, 0, 0, 0, 5'd1, 5'd2, 5'd0);
        sb.push_back({1'b0, 1'b0, 5'd0});
        cyc();
        ex_zero = 1'b1;
        drv(0, 0, 1, 1, 3'b000, 0, 1, 1, 5'd1, 5'd0, 5'd12);
        cyc();
        ex_zero = 1'b0;
        drv(1, 0, 0, 0, 3'b010, 0, 0, 1, 5'd12, 5'd3, 5'd13);
        smp();
        chk("pri_pc_src", pc_src, 1);
        chk("pri_no_stall", ld_stall, 0);
        cyc();
        bub();
        smp();
        chk("pri_ex_squash", ex_valid, 0);
        chk("pri_load_squash", mem_mread, 0);
        drain();

        // Asynchronous reset with a store in MEM
        drv(0, 0, 0, 0, 3'b000, 1, 1, 0, 5'd1, 5'd2, 5'd0);
        cyc();
        drv(1, 0, 0, 0, 3'b010, 0, 0, 1, 5'd3, 5'd4, 5'd14);
        cyc();
        bub();
        smp();
        chk("ar_mwrite_before", mem_mwrite, 1);
        chk("ar_ex_before", ex_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_mwrite_async", mem_mwrite, 0);
        chk("ar_ex_async", ex_valid, 0);
        chk("ar_mem_async", mem_valid, 0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        smp();
        chk("ar_ex_after", ex_valid, 0);
        chk("ar_mem_after", mem_valid, 0);
        cyc(); smp();
        chk("ar_wb_after", wb_valid, 0);
        chk("ar_wb_wr_after", wb_wr, 0);

        // Recovery
        drv(1, 0, 0, 0, 3'b011, 0, 0, 1, 5'd1, 5'd2, 5'd15);
        sb.push_back({1'b0, 1'b1, 5'd15});
        cyc();
        bub();
        repeat (4) cyc();
        smp();
        chk("sb_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ctrl_pipe.md
Name: ctrl_pipe

Overview:
- Consumer-side counterpart of the opcode control decoder.
- Takes the decoded control bundle in ID and carries the EX, M and WB fields through the ID/EX, EX/MEM and MEM/WB pipeline registers.
- Generates the load-use stall and the branch-taken flush.
- Sits between the control decoder and the datapath muxes, ALU control, data memory and register file write port.

Parameters:
- AOP_W, 3, width of the ALU-op field.
- RA_W, 5, register-address width.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  ID holds a real instruction; when low, all other id_* fields are don't-care
- id_regds  in  1  decoded RegDs
- id_branch  in  1  decoded Branch
- id_mread  in  1  decoded MRead
- id_mtor  in  1  decoded MtoR
- id_aop  in  AOP_W  decoded ALU op
- id_mwrite  in  1  decoded MWrite
- id_alusrc  in  1  decoded ALUsrc
- id_urw  in  1  decoded register write
- id_rs  in  RA_W  ID source register 1
- id_rt  in  RA_W  ID source register 2
- id_wr  in  RA_W  ID destination register, already muxed by RegDs
- ex_zero  in  1  ALU zero flag of the instruction in EX
- ex_valid, ex_regds, ex_aop, ex_alusrc  out  1/1/AOP_W/1  EX-stage controls
- mem_valid, mem_branch, mem_mread, mem_mwrite  out  1 each  MEM-stage controls
- wb_valid, wb_mtor, wb_urw  out  1 each  WB-stage controls
- wb_wr  out  RA_W  register-file write address
- ld_stall  out  1  hold PC and IF/ID this cycle
- pc_src  out  1  branch taken; select branch target and flush

Behaviour:
- Reset (rst_n low, asynchronous):
  - All stage registers clear: every valid = 0 and every control field and address = 0.
  - Consequently ld_stall = 0 and pc_src = 0.
  - Release is synchronous to the next clk edge.
- Bubble definition: valid = 0 with all control fields and addresses 0. Bubbles never assert mread, mwrite, urw or branch.
  - id_valid = 0 loads a bubble, so X fields from the decoder default case never propagate.
- Normal advance every clk edge, no global enable:
  - MEM/WB <= EX/MEM.
  - EX/MEM <= ID/EX, also capturing ex_zero as mem_zero (internal).
  - ID/EX <= ID bundle.
- All stage outputs come directly from registers, with zero added latency per stage.
  - An instruction accepted at edge N appears in EX after N, in MEM after N+1 and in WB after N+2.
- ld_stall is combinational and equals the AND of all of:
  - ex_valid
  - ex_mread
  - ex_urw
  - ex_wr != 0
  - ex_wr == id_rs OR ex_wr == id_rt
  - id_valid
  - NOT pc_src
- While ld_stall is high, ID/EX loads a bubble and EX/MEM and MEM/WB advance normally.
  - The upstream stage holds ID, so the stall lasts exactly 1 cycle; the next cycle the load is in MEM and ld_stall drops.
- pc_src = mem_valid AND mem_branch AND mem_zero (registered fields, combinational AND).
  - While pc_src is high, at the next edge ID/EX and EX/MEM both load bubbles; MEM/WB advances normally, since the branch itself completes.
  - This squashes exactly the two wrong-path instructions in ID and EX. pc_src is therefore high for exactly 1 cycle per taken branch.
- Simultaneous events:
  - pc_src has priority and forces ld_stall to 0.
  - A taken branch in MEM together with a load in EX produces no stall, and the load is squashed.
- Not-taken branch (mem_zero = 0): no flush and no bubble.
- Register 0 as destination never causes a stall.
- Reset mid-operation clears in-flight instructions immediately with no write or memory side effects. pc_src and ld_stall drop asynchronously.

Test Plan:
- Reset, then an R-type bundle (regds=1, aop=010, alusrc=0, mtor=1, urw=1, wr=5) with id_valid=1 for 1 cycle:
  - ex_* show the bundle after 1 edge.
  - wb_valid=1, wb_urw=1, wb_wr=5 after 3 edges.
  - All *_valid=0 before and after.
- Load (mread=1, urw=1, wr=8), then an instruction with rs=8 held in ID:
  - ld_stall=1 for exactly 1 cycle.
  - ex_valid=0 the following cycle while mem_mread=1.
  - The dependent instruction reaches EX one cycle later.
- Load to wr=0 followed by a consumer of rs=0 -> ld_stall stays 0.
- Branch with ex_zero=1 in EX, followed by two valid instructions:
  - pc_src=1 for 1 cycle.
  - Next cycle ex_valid=0 and mem_valid=0.
  - No mem_mwrite or wb_urw from the squashed pair.
- Same branch with ex_zero=0 -> pc_src never asserts and both followers retire.
- Taken branch in MEM while a load in EX matches ID rs:
  - ld_stall=0, pc_src=1, load squashed.
- Assert rst_n low mid-stream with a store in MEM:
  - mem_mwrite falls immediately without waiting for clk.
  - All outputs are 0 until new instructions enter.
